// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle control FSM for a shared instruction/data
// memory with ready handshake, wait-state timeout and illegal-instruction trap.
`default_nettype none

module multicycle_control_unit #(
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int MAX_WAIT       = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                op,
  input  logic [2:0]                funct3,
  input  logic                      funct7b5,
  input  logic                      Zero,
  input  logic                      LtS,
  input  logic                      LtU,
  input  logic                      mem_ready,
  output logic                      PCWrite,
  output logic                      AdrSrc,
  output logic                      IRWrite,
  output logic                      MemWrite,
  output logic                      MemRead,
  output logic [2:0]                mem_size,
  output logic                      RegWrite,
  output logic [2:0]                ImmSrc,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [1:0]                ResultSrc,
  output logic [3:0]                state,
  output logic                      trap,
  output logic [1:0]                trap_cause
);

  localparam int              CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALWB    = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14,
    S_AUIPC    = 4'd15
  } state_t;

  state_t           state_q, state_d, dec_state;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             dec_illegal;
  logic             in_wait;
  logic [3:0]       alu_op;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  // Opcode/funct3 decode used only in DECODE; unsupported encodings trap.
  always_comb begin
    dec_state   = S_TRAP;
    dec_illegal = 1'b0;
    case (op)
      7'b0000011: begin
        dec_state   = S_MEMADR;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        dec_state   = S_MEMADR;
        dec_illegal = (funct3 > 3'b010);
      end
      7'b0110011: begin
        dec_state   = S_EXECR;
        dec_illegal = funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      7'b0010011: dec_state = S_EXECI;
      7'b1100011: begin
        dec_state   = S_BRANCH;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      7'b1101111: dec_state = S_JAL;
      7'b1100111: begin
        dec_state   = S_JALR;
        dec_illegal = (funct3 != 3'b000);
      end
      7'b0110111: dec_state = S_LUI;
      7'b0010111: dec_state = S_AUIPC;
      default:    dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = dec_state;
        end
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALWB;
      S_JALWB:    state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        cause_d = 2'b01;
      end
    endcase
    if ((MAX_WAIT != 0) && in_wait && !mem_ready && (wait_cnt_q == CNT_MAX)) begin
      state_d = S_TRAP;
      cause_d = 2'b10;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!in_wait || mem_ready || (state_d != state_q)) wait_cnt_d = '0;
    else if (wait_cnt_q != CNT_MAX)                    wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // ALU op for register and immediate arithmetic; funct7b5 only picks sub in R-type.
  always_comb begin
    alu_op = 4'd0;
    case (funct3)
      3'b000:  alu_op = (funct7b5 && (state_q == S_EXECR)) ? 4'd1 : 4'd0;
      3'b001:  alu_op = 4'd7;
      3'b010:  alu_op = 4'd5;
      3'b011:  alu_op = 4'd6;
      3'b100:  alu_op = 4'd4;
      3'b101:  alu_op = funct7b5 ? 4'd9 : 4'd8;
      3'b110:  alu_op = 4'd3;
      default: alu_op = 4'd2;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    mem_size   = 3'b010;
    RegWrite   = 1'b0;
    ImmSrc     = 3'b000;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = '0;
    ResultSrc  = 2'b00;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == 7'b1101111) ? 3'b100 : 3'b010;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        MemRead  = 1'b1;
        AdrSrc   = 1'b1;
        mem_size = funct3;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        mem_size = funct3;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_CTRL_WIDTH'(alu_op);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_CTRL_WIDTH'(alu_op);
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_CTRL_WIDTH'(4'd1);
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = !Zero;
          3'b100:  PCWrite = LtS;
          3'b101:  PCWrite = !LtS;
          3'b110:  PCWrite = LtU;
          3'b111:  PCWrite = !LtU;
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_JALWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  assign state      = state_q;
  assign trap_cause = cause_q;

endmodule

`default_nettype wire
